// File: rtl/uart_tx_serializer.sv
// Pulls bytes from the TX message memory and sends each as a UART frame, stopping after 0x0A.
// Define UART_TX_PARITY_EN to add an even-parity bit to every frame (8E1 instead of 8N1).
module uart_tx_serializer #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int REQ_LAT   = 2,
    parameter int MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iSTART,
    input  logic [7:0] iTX_DATA,
    output logic       oTX_REQ,
    output logic       oTX,
    output logic       oBUSY,
    output logic       oFINISH
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int WW = (REQ_LAT > 1) ? $clog2(REQ_LAT) : 1;
    localparam int CW = $clog2(MAX_BYTES + 1);

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(REQ_LAT - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_BYTES);

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT, START, DATA, PARITY, STOP, DONE
    } state_t;

    state_t          state;
    logic [TW-1:0]   bit_timer;
    logic [2:0]      bit_idx;
    logic [WW-1:0]   wait_cnt;
    logic [CW-1:0]   byte_cnt;
    logic [7:0]      byte_reg;
    logic            bit_end;
    logic            capture;
    logic [2:0]      next_idx;

    assign bit_end  = (bit_timer == BIT_LAST);
    assign capture  = (state == WAIT) && (wait_cnt == WAIT_LAST);
    assign next_idx = bit_idx + 3'd1;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Byte under transmission; held still for the whole frame so late iTX_DATA changes are ignored.
    always_ff @(posedge clk) begin
        if (capture)
            byte_reg <= iTX_DATA;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_timer <= '0;
            bit_idx   <= '0;
            wait_cnt  <= '0;
            byte_cnt  <= '0;
            oTX_REQ   <= 1'b0;
            oTX       <= 1'b1;
            oBUSY     <= 1'b0;
            oFINISH   <= 1'b0;
        end else begin
            oTX_REQ <= 1'b0;
            oFINISH <= 1'b0;
            if (state inside {START, DATA, PARITY, STOP})
                bit_timer <= bit_end ? '0 : bit_timer + 1'b1;

            case (state)
                IDLE: begin
                    oTX <= 1'b1;
                    if (iSTART) begin
                        state    <= REQ;
                        oTX_REQ  <= 1'b1;
                        oBUSY    <= 1'b1;
                        byte_cnt <= '0;
                    end
                end
                REQ: begin
                    byte_cnt <= sat_inc(byte_cnt);
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        // 0xFF means the memory had nothing; skip it without framing.
                        if (iTX_DATA == 8'hFF) begin
                            if (byte_cnt < CNT_MAX) begin
                                state   <= REQ;
                                oTX_REQ <= 1'b1;
                            end else begin
                                state   <= DONE;
                                oFINISH <= 1'b1;
                            end
                        end else begin
                            state     <= START;
                            oTX       <= 1'b0;
                            bit_timer <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        oTX     <= byte_reg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            oTX   <= ^byte_reg;
`else
                            state <= STOP;
                            oTX   <= 1'b1;
`endif
                        end else begin
                            bit_idx <= next_idx;
                            oTX     <= byte_reg[next_idx];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        oTX   <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (byte_reg == 8'h0A || byte_cnt == CNT_MAX) begin
                            state   <= DONE;
                            oFINISH <= 1'b1;
                        end else begin
                            state   <= REQ;
                            oTX_REQ <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    oTX   <= 1'b1;
                    oBUSY <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomised bench for uart_tx_serializer: a message-memory model feeds bytes on request and every
// cycle's {oTX_REQ, oTX, oBUSY, oFINISH} is compared against a waveform built from the framing rules.
module tb_uart_tx_serializer;

    localparam int CLK_HZ    = 1000;
    localparam int BAUD      = 100;
    localparam int REQ_LAT   = 2;
    localparam int MAX_BYTES = 4;
    localparam int CPB       = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       iSTART;
    logic [7:0] iTX_DATA;
    logic       oTX_REQ;
    logic       oTX;
    logic       oBUSY;
    logic       oFINISH;

    uart_tx_serializer #(
        .CLK_HZ   (CLK_HZ),
        .BAUD     (BAUD),
        .REQ_LAT  (REQ_LAT),
        .MAX_BYTES(MAX_BYTES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .iSTART  (iSTART),
        .iTX_DATA(iTX_DATA),
        .oTX_REQ (oTX_REQ),
        .oTX     (oTX),
        .oBUSY   (oBUSY),
        .oFINISH (oFINISH)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int msg_id = 0;
    logic [7:0] msg_q[$];
    logic [3:0] exp_q[$];

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: {req,tx,busy,fin} got %b expected %b", tag, got, exp);
        end
    endtask

    // Expected per-cycle outputs from the REQ cycle of a message up to and including the IDLE cycle.
    function automatic void build_exp();
        int cnt = 0;
        int k = 0;
        bit done = 1'b0;
        logic [7:0] b;
        logic [10:0] frame;
        exp_q.delete();
        while (!done) begin
            b = (k < msg_q.size()) ? msg_q[k] : 8'h0A;
            k++;
            cnt++;
            exp_q.push_back(4'b1110);
            repeat (REQ_LAT) exp_q.push_back(4'b0110);
            if (b == 8'hFF) begin
                done = (cnt >= MAX_BYTES);
            end else begin
`ifdef UART_TX_PARITY_EN
                frame = {1'b1, ^b, b, 1'b0};
`else
                frame = {1'b0, 1'b1, b, 1'b0};
`endif
                for (int j = 0; j < NBITS; j++)
                    repeat (CPB) exp_q.push_back({1'b0, frame[j], 1'b1, 1'b0});
                done = (b == 8'h0A) || (cnt >= MAX_BYTES);
            end
        end
        exp_q.push_back(4'b0111);
        exp_q.push_back(4'b0100);
    endfunction

    // Caller has already driven iSTART high for the edge that leaves IDLE.
    task automatic run_message(input bit chain, input int stop_at);
        int ptr = 0;
        int pend = 0;
        build_exp();
        msg_id++;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("msg%0d cyc%0d", msg_id, i), {oTX_REQ, oTX, oBUSY, oFINISH}, exp_q[i]);
            if (i == stop_at) return;
            if (oTX_REQ) begin
                pend = REQ_LAT;
                iTX_DATA = 8'($urandom);
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    iTX_DATA = (ptr < msg_q.size()) ? msg_q[ptr] : 8'h0A;
                    ptr++;
                end else begin
                    iTX_DATA = 8'($urandom);
                end
            end else begin
                iTX_DATA = 8'($urandom);
            end
            iSTART = (i == exp_q.size() - 1) ? chain : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle_cycles(input int n);
        iSTART = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            iTX_DATA = 8'($urandom);
            chk("idle", {oTX_REQ, oTX, oBUSY, oFINISH}, 4'b0100);
        end
    endtask

    initial begin
        logic [7:0] b;
        int len;
        int r;
        bit chain;

        reset = 1'b1;
        iSTART = 1'b0;
        iTX_DATA = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_state", {oTX_REQ, oTX, oBUSY, oFINISH}, 4'b0100);
        reset = 1'b0;
        idle_cycles(3);

        // "a" then line feed
        msg_q = '{8'h61, 8'h0A};
        iSTART = 1'b1;
        run_message(1'b0, -1);
        idle_cycles(2);

        // leading empty slot is requested but not framed
        msg_q = '{8'hFF, 8'h41, 8'h0A};
        iSTART = 1'b1;
        run_message(1'b0, -1);
        idle_cycles(2);

        // no line feed: byte-count guard ends the message
        msg_q = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
        iSTART = 1'b1;
        run_message(1'b0, -1);
        idle_cycles(2);

        // parity-sensitive bytes
        msg_q = '{8'h07, 8'h03, 8'h0A};
        iSTART = 1'b1;
        run_message(1'b0, -1);
        idle_cycles(1);

        // back-to-back messages with iSTART held
        msg_q = '{8'h12, 8'h0A};
        iSTART = 1'b1;
        run_message(1'b1, -1);
        msg_q = '{8'h34, 8'hFF, 8'h0A};
        run_message(1'b0, -1);
        idle_cycles(2);

        // reset in the middle of a data bit of an all-zero byte
        msg_q = '{8'h00, 8'h0A};
        iSTART = 1'b1;
        run_message(1'b0, 1 + REQ_LAT + CPB + 15);
        #2 reset = 1'b1;
        #1 chk("reset_async", {oTX_REQ, oTX, oBUSY, oFINISH}, 4'b0100);
        iSTART = 1'b0;
        @(negedge clk);
        chk("reset_held", {oTX_REQ, oTX, oBUSY, oFINISH}, 4'b0100);
        reset = 1'b0;
        idle_cycles(5);

        for (int m = 0; m < 12; m++) begin
            len = $urandom_range(1, 5);
            msg_q.delete();
            for (int j = 0; j < len; j++) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    b = 8'hFF;
                end else if (r == 1) begin
                    b = 8'h0A;
                end else begin
                    b = 8'($urandom_range(0, 253));
                    if (b >= 8'h0A) b = b + 8'd1;
                end
                msg_q.push_back(b);
            end
            chain = (m == 11) ? 1'b0 : 1'($urandom_range(0, 1));
            if (m == 0 || !(iSTART)) iSTART = 1'b1;
            run_message(chain, -1);
            if (!chain) idle_cycles($urandom_range(1, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
